bp_event_counter_bank: RTL

- Parametrised bank of per-event performance counters; successor to the fixed stall-counter block.
- Counts `num_counters_p` single-bit event lines under a global enable and a per-counter mask.
- Takes atomic snapshots into a shadow bank, either periodically, on request, or both, with optional per-window delta mode.
- Shadow values are read out one at a time through a valid/ready read port by the host/AXI-lite shell.

---
 rtl/bp_event_counter_bank_if.sv | 21 ++
 rtl/bp_event_counter_bank.sv | 117 +++++++++++
 2 files changed

// File: rtl/bp_event_counter_bank_if.sv
// Read port of bp_event_counter_bank. The host issues indexed reads and the
// bank returns registered shadow values under a valid/ready/yumi handshake.
interface bp_event_counter_bank_if #(
   parameter int num_counters_p     = 32,
   parameter int width_p            = 32,
   parameter int lg_num_counters_lp = (num_counters_p == 1) ? 1 : $clog2(num_counters_p)
);
   logic                          rd_v_i;
   logic [lg_num_counters_lp-1:0] rd_idx_i;
   logic                          rd_ready_o;
   logic                          rd_v_o;
   logic [width_p-1:0]            rd_data_o;
   logic                          rd_ovf_o;
   logic                          rd_err_o;
   logic                          rd_yumi_i;

   modport master (output rd_v_i, rd_idx_i, rd_yumi_i,
                   input  rd_ready_o, rd_v_o, rd_data_o, rd_ovf_o, rd_err_o);
   modport slave  (input  rd_v_i, rd_idx_i, rd_yumi_i,
                   output rd_ready_o, rd_v_o, rd_data_o, rd_ovf_o, rd_err_o);
endinterface

// File: rtl/bp_event_counter_bank.sv
// Bank of masked per-event counters with periodic/manual atomic snapshots into
// a shadow bank, optional per-window delta restart, and an indexed read port.
module bp_event_counter_bank #(
   parameter int num_counters_p     = 32,
   parameter int width_p            = 32,
   parameter bit saturate_p         = 1'b0,
   parameter bit delta_mode_p       = 1'b0,
   parameter int lg_num_counters_lp = (num_counters_p == 1) ? 1 : $clog2(num_counters_p)
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      clear_i,
   input  logic                      en_i,
   input  logic [num_counters_p-1:0] event_i,
   input  logic [num_counters_p-1:0] mask_i,
   input  logic [width_p-1:0]        snap_interval_i,
   input  logic                      snap_req_i,
   output logic                      snap_v_o,
   output logic [width_p-1:0]        snap_cnt_o,
   bp_event_counter_bank_if.slave    rd
);
   localparam logic [width_p-1:0] max_lp = '1;
   localparam logic [width_p-1:0] one_lp = width_p'(1);

   logic [num_counters_p-1:0] inc;
   logic                      periodic;
   logic                      snap;
   logic [width_p-1:0]        timer_q;
   logic [width_p-1:0]        live_q   [num_counters_p];
   logic [num_counters_p-1:0] ovf_q;
   logic [width_p-1:0]        shadow_q [num_counters_p];
   logic [num_counters_p-1:0] shadow_ovf_q;
   logic                      rd_accept;
   logic                      rd_in_range;

   assign inc      = {num_counters_p{en_i}} & event_i & mask_i;
   // A lowered interval fires on the next enabled cycle since the test is >=.
   assign periodic = en_i && (snap_interval_i != '0) && (timer_q >= snap_interval_i - one_lp);
   assign snap     = snap_req_i | periodic;

   // NOTE: all state uses <= so every register samples pre-edge values; the
   // shadow capture of live_q depends on seeing the count before this edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         timer_q    <= '0;
         snap_cnt_o <= '0;
         snap_v_o   <= 1'b0;
      end else begin
         snap_v_o <= snap;
         if (clear_i || periodic)
            timer_q <= '0;
         else if (en_i && (snap_interval_i != '0))
            timer_q <= timer_q + one_lp;
         if (clear_i)
            snap_cnt_o <= '0;
         else if (snap)
            snap_cnt_o <= snap_cnt_o + one_lp;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < num_counters_p; k++) live_q[k] <= '0;
         ovf_q <= '0;
      end else begin
         for (int k = 0; k < num_counters_p; k++) begin
            if (clear_i) begin
               live_q[k] <= '0;
               ovf_q[k]  <= 1'b0;
            end else if (delta_mode_p && snap) begin
               // This cycle's event opens the next window.
               live_q[k] <= width_p'(inc[k]);
               ovf_q[k]  <= 1'b0;
            end else if (inc[k]) begin
               if (live_q[k] == max_lp) begin
                  ovf_q[k] <= 1'b1;
                  if (!saturate_p) live_q[k] <= '0;
               end else begin
                  live_q[k] <= live_q[k] + one_lp;
               end
            end
         end
      end
   end

   // NOTE: the shadow bank must read 0 out of reset, so it is reset like any
   // other register rather than left as an uninitialised storage array.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < num_counters_p; k++) shadow_q[k] <= '0;
         shadow_ovf_q <= '0;
      end else if (snap) begin
         for (int k = 0; k < num_counters_p; k++) shadow_q[k] <= live_q[k];
         shadow_ovf_q <= ovf_q;
      end
   end

   assign rd.rd_ready_o = ~rd.rd_v_o | rd.rd_yumi_i;
   assign rd_accept     = rd.rd_v_i & rd.rd_ready_o;
   assign rd_in_range   = int'(rd.rd_idx_i) < num_counters_p;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd.rd_v_o    <= 1'b0;
         rd.rd_data_o <= '0;
         rd.rd_ovf_o  <= 1'b0;
         rd.rd_err_o  <= 1'b0;
      end else if (rd_accept) begin
         rd.rd_v_o    <= 1'b1;
         rd.rd_data_o <= rd_in_range ? shadow_q[rd.rd_idx_i] : '0;
         rd.rd_ovf_o  <= rd_in_range ? shadow_ovf_q[rd.rd_idx_i] : 1'b0;
         rd.rd_err_o  <= ~rd_in_range;
      end else if (rd.rd_yumi_i) begin
         rd.rd_v_o <= 1'b0;
      end
   end
endmodule
